// File: rtl/playlist_sequencer_if.sv
// Control/status bundle between the button controller, the mp3 driver and the
// playlist sequencer.
interface playlist_sequencer_if #(
   parameter int unsigned NUM_SONGS = 8,
   parameter int unsigned IDX_W     = 3,
   parameter int unsigned ADDR_W    = 17
);
   logic [NUM_SONGS*ADDR_W-1:0] SONG_BASES;
   logic [NUM_SONGS*ADDR_W-1:0] SONG_SIZES;
   logic [1:0]                  MODE;
   logic                        SUSPEND_P;
   logic                        NEXT_P;
   logic                        LAST_P;
   logic                        WORD_REQ;
   logic [ADDR_W-1:0]           MEM_ADDR;
   logic [IDX_W-1:0]            SONG_NOW;
   logic                        IS_SUSPENDING;
   logic                        SONG_START;
   logic                        PLAYING;

   modport master (
      output SONG_BASES, SONG_SIZES, MODE, SUSPEND_P, NEXT_P, LAST_P, WORD_REQ,
      input  MEM_ADDR, SONG_NOW, IS_SUSPENDING, SONG_START, PLAYING
   );

   modport slave (
      input  SONG_BASES, SONG_SIZES, MODE, SUSPEND_P, NEXT_P, LAST_P, WORD_REQ,
      output MEM_ADDR, SONG_NOW, IS_SUSPENDING, SONG_START, PLAYING
   );
endinterface

// File: rtl/playlist_sequencer.sv
// Song library sequencer: tracks the current song and word offset, generates the
// shared-ROM read address and auto-advances under the selected play mode.
module playlist_sequencer #(
   parameter int unsigned NUM_SONGS = 8,
   parameter int unsigned IDX_W     = 3,
   parameter int unsigned ADDR_W    = 17
) (
   input  logic                 MP3_SCLK,
   input  logic                 RESET_N,
   playlist_sequencer_if.slave  bus
);

   localparam logic [IDX_W-1:0] LastSong = IDX_W'(NUM_SONGS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StSwitch,
      StPlay,
      StPause,
      StEnd,
      StStop
   } state_e;

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  song_q, song_d;
   logic [ADDR_W-1:0] offset_q, offset_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              start_q, start_d;
   logic              susp_q, susp_d;
   logic              play_q, play_d;
   logic [7:0]        lfsr_q, lfsr_d;

   logic [ADDR_W-1:0] bases [2**IDX_W];
   logic [ADDR_W-1:0] sizes [2**IDX_W];

   // Unused index slots read as zero so the tables can be indexed by the full song width.
   for (genvar g = 0; g < 2**IDX_W; g++) begin : g_tables
      if (g < NUM_SONGS) begin : g_used
         assign bases[g] = bus.SONG_BASES[g*ADDR_W +: ADDR_W];
         assign sizes[g] = bus.SONG_SIZES[g*ADDR_W +: ADDR_W];
      end else begin : g_unused
         assign bases[g] = '0;
         assign sizes[g] = '0;
      end
   end

   logic [ADDR_W-1:0] size_now;
   logic [IDX_W-1:0]  song_inc, song_dec, skip_tgt, shuf, tgt;
   logic              skip, load;

   assign size_now = sizes[song_q];
   assign song_inc = (song_q == LastSong) ? '0 : song_q + IDX_W'(1);
   assign song_dec = (song_q == '0) ? LastSong : song_q - IDX_W'(1);
   assign skip     = bus.NEXT_P ^ bus.LAST_P;
   assign skip_tgt = bus.NEXT_P ? song_inc : song_dec;

   assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

   always_comb begin
      shuf = lfsr_q[IDX_W-1:0];
      if ({1'b0, shuf} >= (IDX_W + 1)'(NUM_SONGS)) begin
         shuf = shuf - IDX_W'(NUM_SONGS);
      end
      // Never repeat the current song.
      if (shuf == song_q) begin
         shuf = (shuf == LastSong) ? '0 : shuf + IDX_W'(1);
      end
   end

   always_comb begin
      state_d  = state_q;
      song_d   = song_q;
      offset_d = offset_q;
      addr_d   = addr_q;
      start_d  = 1'b0;
      load     = 1'b0;
      tgt      = song_q;

      unique case (state_q)
         StIdle: begin
            if (bus.SUSPEND_P) begin
               load = 1'b1;
               tgt  = '0;
            end
         end
         StSwitch: begin
            state_d = (size_now == '0) ? StEnd : StPlay;
         end
         StPlay: begin
            if (skip) begin
               load = 1'b1;
               tgt  = skip_tgt;
            end else begin
               if (bus.WORD_REQ) begin
                  offset_d = offset_q + ADDR_W'(1);
                  addr_d   = addr_q + ADDR_W'(1);
                  if (offset_q + ADDR_W'(1) == size_now) state_d = StEnd;
               end
               // A pause arriving with the final word is dropped; end-of-song wins.
               if (bus.SUSPEND_P && state_d != StEnd) state_d = StPause;
            end
         end
         StPause: begin
            if (skip) begin
               load = 1'b1;
               tgt  = skip_tgt;
            end else if (bus.SUSPEND_P) begin
               state_d = StPlay;
            end
         end
         StEnd: begin
            unique case (bus.MODE)
               2'd0: begin
                  if (song_q == LastSong) begin
                     state_d  = StStop;
                     offset_d = '0;
                  end else begin
                     load = 1'b1;
                     tgt  = song_inc;
                  end
               end
               2'd1: begin
                  load = 1'b1;
                  tgt  = song_inc;
               end
               2'd2: begin
                  load = 1'b1;
                  tgt  = song_q;
               end
               default: begin
                  load = 1'b1;
                  tgt  = shuf;
               end
            endcase
         end
         StStop: begin
            if (skip) begin
               load = 1'b1;
               tgt  = skip_tgt;
            end else if (bus.SUSPEND_P) begin
               load = 1'b1;
               tgt  = '0;
            end
         end
         default: state_d = StIdle;
      endcase

      if (load) begin
         state_d  = StSwitch;
         song_d   = tgt;
         offset_d = '0;
         addr_d   = bases[tgt];
         start_d  = 1'b1;
      end

      susp_d = (state_d == StIdle) || (state_d == StPause) || (state_d == StStop);
      play_d = (state_d == StPlay);
   end

   always_ff @(posedge MP3_SCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= StIdle;
         song_q   <= '0;
         offset_q <= '0;
         // Tables are static, so this acts as a constant reset value.
         addr_q   <= bases[0];
         start_q  <= 1'b0;
         susp_q   <= 1'b1;
         play_q   <= 1'b0;
         lfsr_q   <= 8'h01;
      end else begin
         state_q  <= state_d;
         song_q   <= song_d;
         offset_q <= offset_d;
         addr_q   <= addr_d;
         start_q  <= start_d;
         susp_q   <= susp_d;
         play_q   <= play_d;
         lfsr_q   <= lfsr_d;
      end
   end

   assign bus.MEM_ADDR      = addr_q;
   assign bus.SONG_NOW      = song_q;
   assign bus.IS_SUSPENDING = susp_q;
   assign bus.SONG_START    = start_q;
   assign bus.PLAYING       = play_q;

endmodule

// File: tb/tb_playlist_sequencer.sv
// Directed bench for playlist_sequencer: three-song library, every play mode,
// pause, manual skips, simultaneous commands, async reset and a size-0 song.
module tb_playlist_sequencer;

   localparam int unsigned NS = 3;
   localparam int unsigned IW = 2;
   localparam int unsigned AW = 17;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   starts = 0;
   int   base_starts;
   logic [7:0] lfsr_m;

   playlist_sequencer_if #(.NUM_SONGS(NS), .IDX_W(IW), .ADDR_W(AW)) bus ();

   playlist_sequencer #(.NUM_SONGS(NS), .IDX_W(IW), .ADDR_W(AW)) dut (
      .MP3_SCLK (clk),
      .RESET_N  (rst_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (bus.SONG_START) starts <= starts + 1;

   // Reference shuffle generator: 8-bit Fibonacci, taps 8,6,5,4, seed 01.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_m <= 8'h01;
      else        lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs starting at a falling edge; returns at the next falling edge.
   task automatic step(input logic s, input logic n, input logic l, input logic w);
      bus.SUSPEND_P = s;
      bus.NEXT_P    = n;
      bus.LAST_P    = l;
      bus.WORD_REQ  = w;
      @(negedge clk);
      bus.SUSPEND_P = 1'b0;
      bus.NEXT_P    = 1'b0;
      bus.LAST_P    = 1'b0;
      bus.WORD_REQ  = 1'b0;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic words(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc(2);
      rst_n = 1'b1;
   endtask

   task automatic start_play();
      do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1);
   endtask

   function automatic logic [IW-1:0] pick(input logic [7:0] l, input logic [IW-1:0] now);
      int c;
      c = int'(l[IW-1:0]);
      if (c >= NS) c -= NS;
      if (c == int'(now)) c = (c + 1) % NS;
      return IW'(c);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [IW-1:0] prev, exp_song;
      bus.SONG_BASES = {17'd8, 17'd4, 17'd0};
      bus.SONG_SIZES = {17'd4, 17'd4, 17'd4};
      bus.MODE = 2'd1;
      bus.SUSPEND_P = 1'b0;
      bus.NEXT_P = 1'b0;
      bus.LAST_P = 1'b0;
      bus.WORD_REQ = 1'b0;
      @(negedge clk);
      do_reset();
      check("rst_song", 32'(bus.SONG_NOW), 0);
      check("rst_addr", 32'(bus.MEM_ADDR), 0);
      check("rst_susp", 32'(bus.IS_SUSPENDING), 1);
      check("rst_start", 32'(bus.SONG_START), 0);
      check("rst_play", 32'(bus.PLAYING), 0);

      // First play from idle
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("go_start", 32'(bus.SONG_START), 1);
      check("go_song", 32'(bus.SONG_NOW), 0);
      check("go_addr", 32'(bus.MEM_ADDR), 0);
      cyc(1);
      check("go_play", 32'(bus.PLAYING), 1);
      check("go_start_off", 32'(bus.SONG_START), 0);
      words(3);
      check("w3_addr", 32'(bus.MEM_ADDR), 3);
      check("w3_susp", 32'(bus.IS_SUSPENDING), 0);

      // Loop-all across the whole library
      start_play();
      base_starts = starts;
      for (int s = 0; s < 3; s++) begin
         words(2);
         check("loop_mid_addr", 32'(bus.MEM_ADDR), 32'(4 * s + 2));
         words(2);
         cyc(2);
         check("loop_song", 32'(bus.SONG_NOW), 32'((s + 1) % 3));
         check("loop_addr", 32'(bus.MEM_ADDR), 32'(4 * ((s + 1) % 3)));
      end
      check("loop_starts", 32'(starts - base_starts), 3);
      check("loop_play", 32'(bus.PLAYING), 1);

      // Stop-at-end after the last song, then skip out of STOP
      bus.MODE = 2'd0;
      for (int s = 0; s < 2; s++) begin
         words(4);
         cyc(2);
      end
      check("pre_stop_song", 32'(bus.SONG_NOW), 2);
      words(4);
      cyc(1);
      check("stop_susp", 32'(bus.IS_SUSPENDING), 1);
      check("stop_song", 32'(bus.SONG_NOW), 2);
      check("stop_play", 32'(bus.PLAYING), 0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1);
      check("stop_next_song", 32'(bus.SONG_NOW), 0);
      check("stop_next_play", 32'(bus.PLAYING), 1);

      // Repeat-one on song 1, then pause
      step(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1);
      bus.MODE = 2'd2;
      words(4);
      cyc(1);
      check("rep_start", 32'(bus.SONG_START), 1);
      check("rep_song", 32'(bus.SONG_NOW), 1);
      check("rep_addr", 32'(bus.MEM_ADDR), 4);
      cyc(1);
      words(2);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("pause_susp", 32'(bus.IS_SUSPENDING), 1);
      check("pause_play", 32'(bus.PLAYING), 0);
      words(5);
      check("pause_addr", 32'(bus.MEM_ADDR), 6);
      base_starts = starts;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1);
      check("resume_play", 32'(bus.PLAYING), 1);
      check("resume_addr", 32'(bus.MEM_ADDR), 6);
      check("resume_nostart", 32'(starts - base_starts), 0);
      words(1);
      check("resume_word", 32'(bus.MEM_ADDR), 7);

      // Manual skips, wrap and simultaneous commands
      step(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1);
      check("last_song", 32'(bus.SONG_NOW), 0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      check("last_wrap_song", 32'(bus.SONG_NOW), 2);
      check("last_wrap_addr", 32'(bus.MEM_ADDR), 8);
      cyc(1);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      check("both_song", 32'(bus.SONG_NOW), 2);
      check("both_start", 32'(bus.SONG_START), 0);
      check("both_play", 32'(bus.PLAYING), 1);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check("skipsusp_start", 32'(bus.SONG_START), 1);
      check("skipsusp_song", 32'(bus.SONG_NOW), 0);
      cyc(1);
      check("skipsusp_play", 32'(bus.PLAYING), 1);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      check("skipword_addr", 32'(bus.MEM_ADDR), 4);
      cyc(1);
      words(3);
      check("pre_rst_addr", 32'(bus.MEM_ADDR), 7);

      // Asynchronous reset mid-play
      rst_n = 1'b0;
      #1;
      check("arst_song", 32'(bus.SONG_NOW), 0);
      check("arst_addr", 32'(bus.MEM_ADDR), 0);
      check("arst_susp", 32'(bus.IS_SUSPENDING), 1);
      check("arst_play", 32'(bus.PLAYING), 0);
      check("arst_start", 32'(bus.SONG_START), 0);

      // Shuffle: 50 end-of-song picks against the reference generator
      @(negedge clk);
      start_play();
      bus.MODE = 2'd3;
      for (int i = 0; i < 50; i++) begin
         prev = bus.SONG_NOW;
         words(4);
         exp_song = pick(lfsr_m, prev);
         cyc(1);
         check("shuf_song", 32'(bus.SONG_NOW), 32'(exp_song));
         check("shuf_norepeat", 32'(bus.SONG_NOW != prev && bus.SONG_NOW < NS), 1);
         cyc(1);
      end

      // Zero-length song is skipped without any word requests
      bus.SONG_SIZES = {17'd4, 17'd0, 17'd4};
      bus.MODE = 2'd1;
      start_play();
      words(4);
      cyc(1);
      check("z_song1", 32'(bus.SONG_NOW), 1);
      cyc(2);
      check("z_song2", 32'(bus.SONG_NOW), 2);
      check("z_addr", 32'(bus.MEM_ADDR), 8);
      check("z_start", 32'(bus.SONG_START), 1);
      cyc(1);
      check("z_play", 32'(bus.PLAYING), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
